// File: rtl/vend_pkg.sv
// Shared types and default coin constants for the vending change path.
// Packed per-denomination fields put index 0 in the most significant slot.
package vend_pkg;

  typedef enum logic [1:0] {IDLE, SELECT, ISSUE, DONE} state_t;

  localparam int DEF_NUM_COINS = 4;
  localparam int DEF_VAL_W     = 10;

  localparam logic [DEF_VAL_W-1:0] VAL_QUARTER = 10'd25;
  localparam logic [DEF_VAL_W-1:0] VAL_DIME    = 10'd10;
  localparam logic [DEF_VAL_W-1:0] VAL_NICKEL  = 10'd5;
  localparam logic [DEF_VAL_W-1:0] VAL_PENNY   = 10'd1;

  localparam logic [DEF_NUM_COINS*DEF_VAL_W-1:0] DEF_COIN_VALS =
    {VAL_QUARTER, VAL_DIME, VAL_NICKEL, VAL_PENNY};

  // Low bit of field idx inside a packed vector of num fields, each w bits wide.
  function automatic int fld_lo(input int idx, input int num, input int w);
    return (num - 1 - idx) * w;
  endfunction

endpackage

// File: rtl/coin_select.sv
// Combinational greedy picker: lowest-index coin that fits the amount and is in stock.
module coin_select
  import vend_pkg::*;
#(
  parameter int VAL_W     = DEF_VAL_W,
  parameter int NUM_COINS = DEF_NUM_COINS,
  parameter int CNT_W     = 4,
  parameter int IDX_W     = 2
) (
  input  logic [VAL_W-1:0]           remaining,
  input  logic [NUM_COINS*CNT_W-1:0] stock,
  input  logic [NUM_COINS*VAL_W-1:0] vals,
  output logic                       found,
  output logic [IDX_W-1:0]           idx
);

  // Scan from the smallest coin upward so the lowest matching index wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = NUM_COINS - 1; i >= 0; i--) begin
      if ((vals[fld_lo(i, NUM_COINS, VAL_W) +: VAL_W] <= remaining) &&
          (stock[fld_lo(i, NUM_COINS, CNT_W) +: CNT_W] != '0)) begin
        found = 1'b1;
        idx   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/coin_change_dispenser.sv
// Inventory-aware change dispenser: greedy coin choice limited by tube stock,
// one coin per valid/ready handshake, with shortfall reporting and IDLE-time restock.
module coin_change_dispenser
  import vend_pkg::*;
#(
  parameter int VAL_W     = DEF_VAL_W,
  parameter int NUM_COINS = DEF_NUM_COINS,
  parameter int CNT_W     = 4,
  parameter logic [NUM_COINS*VAL_W-1:0] COIN_VALS  = DEF_COIN_VALS,
  parameter logic [NUM_COINS*CNT_W-1:0] INIT_STOCK = {NUM_COINS{CNT_W'(8)}},
  localparam int IDX_W = (NUM_COINS > 1) ? $clog2(NUM_COINS) : 1
) (
  input  logic                       CLOCK_50,
  input  logic                       reset,
  input  logic                       start,
  input  logic [VAL_W-1:0]           change,
  output logic                       coin_valid,
  output logic [IDX_W-1:0]           coin_idx,
  input  logic                       coin_ready,
  input  logic                       restock,
  input  logic [IDX_W-1:0]           restock_sel,
  input  logic [CNT_W-1:0]           restock_cnt,
  output logic                       busy,
  output logic                       done,
  output logic                       short,
  output logic [VAL_W-1:0]           remaining,
  output logic [NUM_COINS*CNT_W-1:0] disp_cnt,
  output logic [NUM_COINS*CNT_W-1:0] stock
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] stock_q [NUM_COINS];
  logic [CNT_W-1:0] disp_q  [NUM_COINS];
  logic [VAL_W-1:0] val_arr [NUM_COINS];
  logic             found;
  logic [IDX_W-1:0] pick;
  logic [CNT_W:0]   restock_sum;

  for (genvar i = 0; i < NUM_COINS; i++) begin : g_pack
    assign stock[fld_lo(i, NUM_COINS, CNT_W) +: CNT_W]    = stock_q[i];
    assign disp_cnt[fld_lo(i, NUM_COINS, CNT_W) +: CNT_W] = disp_q[i];
    assign val_arr[i] = COIN_VALS[fld_lo(i, NUM_COINS, VAL_W) +: VAL_W];
  end

  coin_select #(
    .VAL_W     (VAL_W),
    .NUM_COINS (NUM_COINS),
    .CNT_W     (CNT_W),
    .IDX_W     (IDX_W)
  ) u_select (
    .remaining (remaining),
    .stock     (stock),
    .vals      (COIN_VALS),
    .found     (found),
    .idx       (pick)
  );

  // One extra bit catches the carry so restock can clamp at full scale.
  assign restock_sum = {1'b0, stock_q[restock_sel]} + {1'b0, restock_cnt};

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    busy       = 1'b1;
    done       = 1'b0;
    coin_valid = 1'b0;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) state_d = SELECT;
      end
      SELECT: begin
        if ((remaining == '0) || !found) state_d = DONE;
        else                             state_d = ISSUE;
      end
      ISSUE: begin
        coin_valid = 1'b1;
        if (coin_ready) state_d = SELECT;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      coin_idx  <= '0;
      remaining <= '0;
      short     <= 1'b0;
      for (int i = 0; i < NUM_COINS; i++) begin
        stock_q[i] <= INIT_STOCK[fld_lo(i, NUM_COINS, CNT_W) +: CNT_W];
        disp_q[i]  <= '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            remaining <= change;
            short     <= 1'b0;
            for (int i = 0; i < NUM_COINS; i++) disp_q[i] <= '0;
          end else if (restock && (int'(restock_sel) < NUM_COINS)) begin
            stock_q[restock_sel] <= restock_sum[CNT_W] ? CNT_MAX : restock_sum[CNT_W-1:0];
          end
        end
        SELECT: begin
          if (remaining == '0) short    <= 1'b0;
          else if (!found)     short    <= 1'b1;
          else                 coin_idx <= pick;
        end
        ISSUE: begin
          // Selection guaranteed the coin fits, so remaining cannot wrap.
          if (coin_ready) begin
            remaining         <= remaining - val_arr[coin_idx];
            stock_q[coin_idx] <= stock_q[coin_idx] - 1'b1;
            if (disp_q[coin_idx] != CNT_MAX) disp_q[coin_idx] <= disp_q[coin_idx] + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_coin_change_dispenser.sv
// Bench for coin_change_dispenser: transaction-level greedy model, per-cycle compare,
// directed scenarios with literal expectations, then randomized traffic.
module tb_coin_change_dispenser;

  localparam int N = 4;
  localparam logic [15:0] INIT_PK = 16'h8088;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [9:0]  change = '0;
  logic        coin_ready = 1'b1;
  logic        restock = 1'b0;
  logic [1:0]  restock_sel = '0;
  logic [3:0]  restock_cnt = '0;
  logic        coin_valid, busy, done, short;
  logic [1:0]  coin_idx;
  logic [9:0]  remaining;
  logic [15:0] disp_cnt, stock;

  coin_change_dispenser #(.INIT_STOCK(INIT_PK)) dut (
    .CLOCK_50(clk), .reset(rst), .start(start), .change(change),
    .coin_valid(coin_valid), .coin_idx(coin_idx), .coin_ready(coin_ready),
    .restock(restock), .restock_sel(restock_sel), .restock_cnt(restock_cnt),
    .busy(busy), .done(done), .short(short), .remaining(remaining),
    .disp_cnt(disp_cnt), .stock(stock)
  );

  always #5 clk = ~clk;

  int     n_cmp = 0;
  int     n_fail = 0;
  int     vals[N]      = '{25, 10, 5, 1};
  int     init_arr[N]  = '{8, 0, 8, 8};
  int     m_stock[N];
  int     exp_disp[N];
  int     exp_rem, exp_short;
  int     exp_coins[$];
  longint got_code;
  int     done_cnt = 0;
  bit     prev_wait = 0, prev_done = 0;
  logic [1:0] prev_idx;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] pack4(input int a[N]);
    logic [15:0] r = '0;
    for (int i = 0; i < N; i++) r[(N-1-i)*4 +: 4] = 4'(a[i]);
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_stock[i]  = init_arr[i];
      exp_disp[i] = 0;
    end
    exp_rem = 0; exp_short = 0;
    exp_coins.delete();
    prev_wait = 0; prev_done = 0;
  endtask

  // Greedy payout against the model inventory, computed for the whole transaction.
  task automatic model_start(input int c);
    int  r = c;
    bit  go = 1;
    exp_coins.delete();
    for (int i = 0; i < N; i++) exp_disp[i] = 0;
    while (go && r > 0) begin
      go = 0;
      for (int i = 0; i < N; i++) begin
        if (!go && vals[i] <= r && m_stock[i] > 0) begin
          go = 1;
          exp_coins.push_back(i);
          r -= vals[i];
          m_stock[i]--;
          if (exp_disp[i] < 15) exp_disp[i]++;
        end
      end
    end
    exp_rem = r;
    exp_short = (r > 0) ? 1 : 0;
  endtask

  task automatic model_restock(input int sel, input int cnt);
    m_stock[sel] = (m_stock[sel] + cnt > 15) ? 15 : m_stock[sel] + cnt;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (coin_valid) begin
        if (prev_wait) chk("idx_stable", coin_idx, prev_idx);
        if (coin_ready) begin
          if (exp_coins.size() == 0) chk("unexpected_coin", 1, 0);
          else chk("coin_idx", coin_idx, exp_coins.pop_front());
          got_code = got_code * 10 + coin_idx + 1;
        end
        prev_wait = !coin_ready;
        prev_idx  = coin_idx;
      end else begin
        prev_wait = 0;
      end
      if (done) begin
        done_cnt++;
        chk("done_single", prev_done, 0);
        chk("remaining", remaining, exp_rem);
        chk("short", short, exp_short);
        chk("disp_cnt", disp_cnt, pack4(exp_disp));
        chk("stock_done", stock, pack4(m_stock));
        chk("coins_left", exp_coins.size(), 0);
      end
      prev_done = done;
      if (!busy) begin
        chk("idle_valid", coin_valid, 0);
        chk("idle_stock", stock, pack4(m_stock));
      end
    end
  end

  task automatic wait_done(input int mode);
    bit ok = done;
    for (int k = 0; k < 400 && !ok; k++) begin
      @(posedge clk); #1;
      if (mode != 0) coin_ready = ($urandom_range(0, 2) != 0);
      ok = done;
    end
    if (!ok) chk("done_timeout", 0, 1);
    coin_ready = 1'b1;
    @(posedge clk); #1;
    chk("idle_after_done", busy, 0);
  endtask

  // mode 0: ready high; 1: random ready; 2: ready low 5 cycles on first coin;
  // 3: random ready with a simultaneous restock that must be dropped.
  task automatic run_txn(input int c, input int mode);
    int d0 = done_cnt;
    got_code = 0;
    coin_ready = (mode == 2) ? 1'b0 : 1'b1;
    @(posedge clk); #1;
    start = 1'b1; change = 10'(c);
    if (mode == 3) begin
      restock = 1'b1; restock_sel = 2'($urandom_range(0, 3)); restock_cnt = 4'($urandom_range(1, 15));
    end
    @(posedge clk); #1;
    start = 1'b0; restock = 1'b0;
    model_start(c);
    chk("busy_n1", busy, 1);
    @(posedge clk); #1;
    if (exp_coins.size() > 0) chk("valid_n2", coin_valid, 1);
    else begin
      chk("done_n2", done, 1);
      chk("novalid_n2", coin_valid, 0);
    end
    if (mode == 2) begin
      for (int k = 0; k < 4; k++) begin
        @(posedge clk); #1;
        chk("hold_valid", coin_valid, 1);
        chk("hold_idx", coin_idx, 0);
      end
      coin_ready = 1'b1;
    end
    wait_done(mode == 1 || mode == 3);
    chk("done_pulses", done_cnt - d0, 1);
  endtask

  task automatic do_restock(input int sel, input int cnt);
    @(posedge clk); #1;
    restock = 1'b1; restock_sel = 2'(sel); restock_cnt = 4'(cnt);
    @(posedge clk); #1;
    restock = 1'b0;
    model_restock(sel, cnt);
  endtask

  initial begin
    bit ok;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", coin_valid, 0);
    chk("rst_idx", coin_idx, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_short", short, 0);
    chk("rst_rem", remaining, 0);
    chk("rst_disp", disp_cnt, 0);
    chk("rst_stock", stock, INIT_PK);
    rst = 1'b0;

    // Empty dime tube: 30 pays as quarter + nickel.
    run_txn(30, 0);
    chk("seq30", got_code, 13);
    chk("stock30", stock, 16'h7078);

    // Refill dimes, saturate nickels, then full greedy run on 41.
    do_restock(1, 8);
    do_restock(2, 15);
    chk("stock_restock", stock, 16'h78F8);
    run_txn(41, 0);
    chk("seq41", got_code, 1234);
    chk("disp41", disp_cnt, 16'h1111);
    chk("rem41", remaining, 0);
    chk("stock41", stock, 16'h67E7);

    // Backpressure on the first coin.
    run_txn(40, 2);
    chk("seq40", got_code, 123);
    chk("stock40", stock, 16'h56D7);

    // start and restock while busy are dropped.
    got_code = 0;
    @(posedge clk); #1; start = 1'b1; change = 10'd10;
    @(posedge clk); #1; start = 1'b0; model_start(10);
    start = 1'b1; change = 10'd99; restock = 1'b1; restock_sel = 2'd3; restock_cnt = 4'd5;
    @(posedge clk); #1; start = 1'b0; restock = 1'b0;
    wait_done(0);
    @(posedge clk); #1;
    chk("busy_ignored", busy, 0);
    chk("seq10", got_code, 2);
    chk("stock10", stock, 16'h55D7);
    run_txn(0, 0);
    chk("seq0", got_code, 0);
    chk("disp0", disp_cnt, 0);

    // Reset while the second coin is on offer.
    got_code = 0; coin_ready = 1'b0;
    @(posedge clk); #1; start = 1'b1; change = 10'd35;
    @(posedge clk); #1; start = 1'b0; model_start(35);
    ok = 0;
    for (int k = 0; k < 10 && !ok; k++) begin @(posedge clk); #1; ok = coin_valid; end
    chk("first_valid", ok, 1);
    coin_ready = 1'b1;
    @(posedge clk); #1; coin_ready = 1'b0;
    ok = 0;
    for (int k = 0; k < 10 && !ok; k++) begin @(posedge clk); #1; ok = coin_valid; end
    chk("second_valid", ok, 1);
    chk("second_idx", coin_idx, 1);
    rst = 1'b1; model_reset();
    #1;
    chk("arst_valid", coin_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_rem", remaining, 0);
    chk("arst_disp", disp_cnt, 0);
    chk("arst_stock", stock, INIT_PK);
    repeat (2) @(posedge clk);
    #1; rst = 1'b0; coin_ready = 1'b1;
    run_txn(25, 0);
    chk("seq25", got_code, 1);
    chk("stock25", stock, 16'h7088);

    // Drain to pennies=2 only, then come up one cent short.
    run_txn(175, 0);
    chk("seq175", got_code, 1111111);
    run_txn(40, 0);
    chk("seq_nickels", got_code, 33333333);
    run_txn(6, 1);
    chk("stock6", stock, 16'h0002);
    run_txn(3, 0);
    chk("seq3", got_code, 44);
    chk("short3", short, 1);
    chk("rem3", remaining, 1);
    chk("disp3", disp_cnt, 16'h0002);
    chk("stock3", stock, 16'h0000);

    // Randomized traffic.
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 2) == 0) do_restock($urandom_range(0, 3), $urandom_range(0, 15));
      run_txn($urandom_range(0, 120), ($urandom_range(0, 3) == 0) ? 3 : 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/coin_change_dispenser.md
Name: coin_change_dispenser

Overview:
- Sequential, inventory-aware change dispenser for the vending machine datapath.
- Accepts a change amount from the paid/owed subtraction and issues one coin at a time over a valid/ready handshake to the coin-release mechanism.
- Uses greedy selection limited by per-denomination tube stock, so an empty tube falls through to smaller coins; reports any shortfall.
- Denomination count, values, count width and value width are parametrised. It replaces the purely count-based greedy calculator.

Parameters:
- VAL_W, 10, width of change and remaining amounts in cents.
- NUM_COINS, 4, number of denominations; index 0 is the highest value.
- CNT_W, 4, width of per-denomination stock and dispensed counters.
- COIN_VALS, {10'd25,10'd10,10'd5,10'd1}, packed NUM_COINS*VAL_W coin values in strictly descending order.
- INIT_STOCK, all fields 4'd8, packed NUM_COINS*CNT_W tube stock loaded at reset.

Ports:
- CLOCK_50  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to dispense `change`; sampled only in IDLE.
- change  in  VAL_W  amount to dispense; captured on an accepted start.
- coin_valid  out  1  a coin is being offered.
- coin_idx  out  $clog2(NUM_COINS)  denomination being offered.
- coin_ready  in  1  mechanism accepts the offered coin.
- restock  in  1  one-cycle request to add coins to one tube; honoured in IDLE only.
- restock_sel  in  $clog2(NUM_COINS)  tube selected for restock.
- restock_cnt  in  CNT_W  number of coins to add.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at end of transaction.
- short  out  1  last transaction could not pay the full amount; held until the next accepted start.
- remaining  out  VAL_W  amount still owed to the customer.
- disp_cnt  out  NUM_COINS*CNT_W  coins dispensed per denomination in the current or last transaction.
- stock  out  NUM_COINS*CNT_W  current tube inventory.

Behaviour:
- Reset (async, any state):
  - FSM goes to IDLE.
  - coin_valid=0, coin_idx=0, busy=0, done=0, short=0, remaining=0, disp_cnt=0.
  - stock=INIT_STOCK.
  - An in-flight coin is abandoned and no counter is updated.
- States: IDLE, SELECT, ISSUE, DONE.
- IDLE:
  - start=1: remaining<=change, disp_cnt<=0, short<=0, go to SELECT.
  - Otherwise, if restock=1: stock[sel]<=min(stock[sel]+restock_cnt, 2^CNT_W-1).
  - start and restock together: start wins and the restock is dropped.
- SELECT (one cycle):
  - Pick the lowest index i with COIN_VALS[i]<=remaining and stock[i]>0.
  - remaining==0: go to DONE, short=0.
  - No candidate with remaining>0: go to DONE, short=1.
  - Otherwise register coin_idx<=i and go to ISSUE.
- ISSUE:
  - coin_valid=1.
  - coin_idx is held stable while coin_ready=0, for any number of cycles.
  - On coin_valid&&coin_ready in the same cycle:
    - remaining -= COIN_VALS[idx];
    - stock[idx] -= 1;
    - disp_cnt[idx] += 1, saturating at 2^CNT_W-1;
    - coin_valid drops the next cycle and the FSM returns to SELECT.
- DONE: done=1 for exactly one cycle, then IDLE. remaining, short and disp_cnt hold their values.
- Ignored inputs:
  - start while busy is ignored; it is not queued.
  - restock while busy is ignored.
- Latency: start at edge N gives busy at N+1 and the first coin_valid at N+2.
  - Each accepted coin adds 2 cycles (SELECT plus handshake).
  - change=0 gives done at N+2 with no coin issued.
- Arithmetic: remaining never underflows, because selection guarantees COIN_VALS[i]<=remaining. All value arithmetic is VAL_W bits unsigned.

Decomposition:
- Shared package vend_pkg holds:
  - the state enum (IDLE/SELECT/ISSUE/DONE);
  - the default US coin value constants (25/10/5/1) and the default NUM_COINS.
- One sub-module, coin_select: combinational priority picker.
  - Inputs: remaining, packed stock, packed values.
  - Outputs: found, idx.
  - Instantiated once by the FSM module.

Test Plan:
- Full stock, change=41, coin_ready tied 1 -> coin_idx sequence 0,1,2,3; disp_cnt={1,1,1,1}; remaining=0; short=0; done pulses once; each stock decreases by 1.
- Dime tube restocked from empty: reset with INIT dimes=0, change=30 -> coins 0 then 2 (25+5), no dime issued; done, short=0.
- Pennies stock=2, all other tubes empty, change=3 -> two penny coins, then done with short=1, remaining=1, disp_cnt[3]=2.
- change=40, coin_ready held low 5 cycles on the first coin -> coin_valid=1 and coin_idx=0 stable throughout; the coin is counted exactly once when ready rises.
- start pulsed while busy, and restock while busy -> both ignored; a second start in IDLE with change=0 -> done at start+2, no coin_valid.
- Assert reset during ISSUE of the second coin -> all outputs return to reset values immediately and stock returns to INIT_STOCK; a subsequent change=25 transaction completes normally.
